// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcode/funct/ALU encodings and control bundle types
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       zero_ext;
        logic       mem_write;
        logic       mem_to_reg;
        logic [2:0] alu_control;
    } ctrl_bundle_t;

    // Only the fields still consumed after EX travel further down the pipe.
    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
    } mem_bundle_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational opcode/funct decode into a control bundle
import ctrl_pkg::*;

module ctrl_decoder #(
    parameter int EXT_ISA = 1
) (
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    input  logic         id_valid,
    output ctrl_bundle_t ctrl,
    output logic         branch_eq,
    output logic         branch_ne,
    output logic         jump,
    output logic         illegal
);

    logic         legal;
    logic         beq;
    logic         bne;
    logic         jmp;
    ctrl_bundle_t raw;

    // Decode opcode/funct; extended instructions are legal only when EXT_ISA is set.
    always_comb begin
        raw   = CTRL_BUBBLE;
        legal = 1'b1;
        beq   = 1'b0;
        bne   = 1'b0;
        jmp   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                raw.reg_write = 1'b1;
                raw.reg_dst   = 1'b1;
                case (funct)
                    FN_ADD:  raw.alu_control = ALU_ADD;
                    FN_SUB:  raw.alu_control = ALU_SUB;
                    FN_AND:  raw.alu_control = ALU_AND;
                    FN_OR:   raw.alu_control = ALU_OR;
                    FN_SLT:  raw.alu_control = ALU_SLT;
                    FN_NOR: begin
                        if (EXT_ISA != 0) raw.alu_control = ALU_NOR;
                        else              legal = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_LW: begin
                raw.reg_write   = 1'b1;
                raw.alu_src     = 1'b1;
                raw.mem_to_reg  = 1'b1;
                raw.alu_control = ALU_ADD;
            end
            OP_SW: begin
                raw.alu_src     = 1'b1;
                raw.mem_write   = 1'b1;
                raw.alu_control = ALU_ADD;
            end
            OP_BEQ: begin
                raw.alu_control = ALU_SUB;
                beq             = 1'b1;
            end
            OP_ADDI: begin
                raw.reg_write   = 1'b1;
                raw.alu_src     = 1'b1;
                raw.alu_control = ALU_ADD;
            end
            OP_BNE: begin
                if (EXT_ISA != 0) begin
                    raw.alu_control = ALU_SUB;
                    bne             = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_SLTI: begin
                raw.reg_write   = 1'b1;
                raw.alu_src     = 1'b1;
                raw.alu_control = ALU_SLT;
                if (EXT_ISA == 0) legal = 1'b0;
            end
            OP_ANDI: begin
                raw.reg_write   = 1'b1;
                raw.alu_src     = 1'b1;
                raw.zero_ext    = 1'b1;
                raw.alu_control = ALU_AND;
                if (EXT_ISA == 0) legal = 1'b0;
            end
            OP_ORI: begin
                raw.reg_write   = 1'b1;
                raw.alu_src     = 1'b1;
                raw.zero_ext    = 1'b1;
                raw.alu_control = ALU_OR;
                if (EXT_ISA == 0) legal = 1'b0;
            end
            OP_J: begin
                if (EXT_ISA != 0) jmp   = 1'b1;
                else              legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    end

    // Undecodable instructions collapse to a bubble so nothing downstream writes.
    assign ctrl      = legal ? raw : CTRL_BUBBLE;
    assign branch_eq = id_valid & legal & beq;
    assign branch_ne = id_valid & legal & bne;
    assign jump      = id_valid & legal & jmp;
    assign illegal   = id_valid & ~legal;

endmodule

// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - pipelined control unit with ID/EX, EX/MEM, MEM/WB stage registers
import ctrl_pkg::*;

module control_pipe #(
    parameter int ALU_CTRL_W = 3,
    parameter int EXT_ISA    = 1,
    parameter int ILL_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  id_valid,
    input  logic                  stall_id,
    input  logic                  flush_ex,
    output logic                  id_branch_eq,
    output logic                  id_branch_ne,
    output logic                  id_jump,
    output logic                  id_illegal,
    output logic [ALU_CTRL_W-1:0] ex_alu_control,
    output logic                  ex_alu_src,
    output logic                  ex_zero_ext,
    output logic                  ex_reg_dst,
    output logic                  ex_mem_to_reg,
    output logic                  ex_reg_write,
    output logic                  mem_mem_write,
    output logic                  mem_mem_to_reg,
    output logic                  mem_reg_write,
    output logic                  wb_mem_to_reg,
    output logic                  wb_reg_write,
    output logic [ILL_CNT_W-1:0]  ill_count
);

    ctrl_bundle_t dec_ctrl;
    ctrl_bundle_t id_ex;
    mem_bundle_t  ex_mem;
    wb_bundle_t   mem_wb;
    logic         load_bubble;

    ctrl_decoder #(
        .EXT_ISA (EXT_ISA)
    ) u_decoder (
        .opcode    (opcode),
        .funct     (funct),
        .id_valid  (id_valid),
        .ctrl      (dec_ctrl),
        .branch_eq (id_branch_eq),
        .branch_ne (id_branch_ne),
        .jump      (id_jump),
        .illegal   (id_illegal)
    );

    assign load_bubble = ~id_valid | id_illegal | stall_id | flush_ex;

    // Advance the three stage registers; only ID/EX can take a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_ex  <= CTRL_BUBBLE;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            id_ex             <= load_bubble ? CTRL_BUBBLE : dec_ctrl;
            ex_mem.reg_write  <= id_ex.reg_write;
            ex_mem.mem_write  <= id_ex.mem_write;
            ex_mem.mem_to_reg <= id_ex.mem_to_reg;
            mem_wb.reg_write  <= ex_mem.reg_write;
            mem_wb.mem_to_reg <= ex_mem.mem_to_reg;
        end
    end

    // Saturating illegal counter; a stalled instruction is counted when it finally leaves ID.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ill_count <= '0;
        end else if (id_illegal && !stall_id && (ill_count != {ILL_CNT_W{1'b1}})) begin
            ill_count <= ill_count + 1'b1;
        end
    end

    assign ex_alu_control = ALU_CTRL_W'(id_ex.alu_control);
    assign ex_alu_src     = id_ex.alu_src;
    assign ex_zero_ext    = id_ex.zero_ext;
    assign ex_reg_dst     = id_ex.reg_dst;
    assign ex_mem_to_reg  = id_ex.mem_to_reg;
    assign ex_reg_write   = id_ex.reg_write;
    assign mem_mem_write  = ex_mem.mem_write;
    assign mem_mem_to_reg = ex_mem.mem_to_reg;
    assign mem_reg_write  = ex_mem.reg_write;
    assign wb_mem_to_reg  = mem_wb.mem_to_reg;
    assign wb_reg_write   = mem_wb.reg_write;

endmodule
